alu_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares one 64-bit combinational ALU between two requesters. Each requester presents operands A/B, a 5-bit select and a carry-in over a valid/ready handshake. The block registers the winning operation onto the ALU input ports, captures the ALU result one cycle later, and returns it on a per-requester response handshake. It sits between the ALU and its clients and owns the ALU's `Ain`/`Bin`/`sel`/`c` inputs.

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional build macro ALU_ARB_ZERO_FLAG_EN adds a registered result-is-zero flag, rsp_zero.
module alu_arbiter #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic             rsp_zero,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic             grant_vld;
  logic             grant;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept    = (state_q == IDLE) && grant_vld && !rst;
    rsp_hs    = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    alu_a_d   = grant ? req1_a   : req0_a;
    alu_b_d   = grant ? req1_b   : req0_b;
    alu_sel_d = grant ? req1_sel : req0_sel;
    alu_cin_d = grant ? req1_cin : req0_cin;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && grant_vld && !grant && !rst;
    req1_ready = (state_q == IDLE) && grant_vld &&  grant && !rst;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) &&  owner_q;
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_q <= grant;
        owner_q      <= grant;
        alu_a_q      <= alu_a_d;
        alu_b_q      <= alu_b_d;
        alu_sel_q    <= alu_sel_d;
        alu_cin_q    <= alu_cin_d;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_o;
        rsp_zero_q <= (alu_o == '0);
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign alu_cin  = alu_cin_q;
  assign rsp_data = rsp_data_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  assign rsp_zero = rsp_zero_q;
`else
  logic unused_zero;
  assign unused_zero = rsp_zero_q;
`endif

endmodule
